aes_iter_core: RTL and testbench
================================

# aes_iter_core

Parametrised iterative AES encryption core supporting AES-128/192/256 through the key-length parameter `NK`. It sits between a block-source stream and a ciphertext sink, with ready/valid handshakes on both sides. It carries an opaque tag alongside each block, holds its output under back-pressure, and has deterministic latency. Successor to the fixed AES-128 start/done top level; it uses one S-box stage per round.

## Interface
- `NK`, default 4: key length in 32-bit words; legal values are 4, 6 and 8. Any other value is an elaboration error.
- `NR`, default `NK+6`: round count, derived and not overridable.
- `TAG_W`, default 4: width of the pass-through tag (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_valid` in 1: input block valid.
- `i_ready` out 1: core can accept a block.
- `i_plaintext` in 128: plaintext block, FIPS-197 byte order (byte 0 = bits [127:120]).
- `i_key` in 32*NK: cipher key, FIPS-197 order.
- `i_tag` in TAG_W: tag returned unchanged with the result.
- `o_valid` out 1: ciphertext valid.
- `o_ready` in 1: sink accepts the ciphertext.
- `o_ciphertext` out 128: result block.
- `o_tag` out TAG_W: tag of the block in `o_ciphertext`.

## Operation
- Reset clears every register. During reset: `i_ready`=0, `o_valid`=0, `o_ciphertext`=0, `o_tag`=0, state = IDLE, `round_ctr`=0, and all round keys = 0.
- FSM states:
  - IDLE: `i_ready`=1. On `i_valid`, accept the block and go to SUB.
  - SUB: register SubBytes(state), then go to RND.
  - RND: compute ShiftRows, then MixColumns, then AddRoundKey(rk[round_ctr]), and write back to state. MixColumns is omitted when `round_ctr`==NR. If `round_ctr`<NR, increment `round_ctr` and go to SUB. Otherwise go to OUT.
  - OUT: `o_valid`=1. When `o_ready` is high, go to IDLE.
- On the accept edge:
  - Latch all NR+1 round keys from the combinational key expansion of `i_key`.
  - Set state ← `i_plaintext` ^ rk[0].
  - Latch `i_tag`.
  - Set `round_ctr` ← 1.
- The key is captured per block. Consecutive blocks may use different keys and key lengths never mix (NK is fixed per instance).
- Only the FSM state drives `i_ready`; it does not depend combinationally on `o_ready`. Inputs are ignored outside IDLE.
- `o_ciphertext` and `o_tag` are taken directly from state registers. They stay stable throughout OUT regardless of `o_ready`, and hold their last value after the handshake until the next result overwrites them.
- `i_valid` dropping, or `i_plaintext` changing, outside the accept edge has no effect.
- Reset asserted mid-operation aborts the block immediately. Nothing is output for that block, and the core returns to IDLE with `i_ready`=1 on the first clock after reset is released.

## Timing
- Accept edge E0 is a clock edge where `i_valid`=1 and `i_ready`=1.
- `o_valid` rises after edge E(2·NR): 20 cycles for NK=4, 24 for NK=6, 28 for NK=8.
- Output handshake edge Eh is a clock edge where `o_valid`=1 and `o_ready`=1. After Eh, `o_valid`=0 and `i_ready`=1. The earliest next accept is at Eh+1.
- Throughput with `o_ready` tied high is one block per 2·NR+2 cycles.
- Each stall cycle with `o_ready`=0 in OUT adds exactly one cycle and changes no output.
- Round key rk[r] is used in the RND cycle where `round_ctr`=r. `round_ctr` is 4 bits wide, counts 1..NR, and never wraps.
- There is no combinational path from any input to any output.

## Test plan
- **Reset values and AES-128.** NK=4.
  - Check the reset values of every output first.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, tag 0x5.
  - Required response: `o_ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a, `o_tag`=0x5, `o_valid` 20 cycles after accept.
- **AES-192.** NK=6, key 000102…1617, same pt.
  - Required response: dda97ca4864cdfe06eaf70a0ec0d7191 at 24 cycles.
- **AES-256.** NK=8, key 000102…1e1f, same pt.
  - Required response: 8ea2b7ca516745bfeafc49904b496089 at 28 cycles.
- **Back-pressure.** NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Stimulus: hold `o_ready`=0 for 7 cycles during OUT.
  - Required response: 3925841d02dc09fbdc118597196a0b32 is held stable with `o_valid`=1 and `i_ready`=0 throughout. The new `i_valid` presented meanwhile is not accepted.
- **Back-to-back blocks.** Two blocks with different keys and tags 0x1 and 0x2, `o_ready`=1.
  - Required response: both correct results, tags in order, with a 22-cycle spacing between `o_valid` pulses.
- **Reset mid-block.**
  - Stimulus: assert `rst` asynchronously in round 5.
  - Required response: outputs clear at once and no `o_valid` appears for that block. A fresh block accepted after release yields the correct FIPS value.

Source files
------------

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryption core: one SubBytes stage and one round stage per round.
// Round keys are expanded combinationally from i_key and captured with each accepted block.
module aes_iter_core #(
  parameter int unsigned NK    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [127:0]       i_plaintext,
  input  logic [32*NK-1:0]   i_key,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [127:0]       o_ciphertext,
  output logic [TAG_W-1:0]   o_tag
);

  localparam int unsigned NR  = NK + 6;
  localparam int          NKI = NK;
  localparam int          NRI = NR;
  localparam int          NW  = 4 * (NRI + 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
    $error("aes_iter_core: NK must be 4, 6 or 8");
  end

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  // Byte 4c+r holds row r of column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Round key r is returned in bits [128*r +: 128].
  function automatic logic [128*(NR+1)-1:0] key_expand(input logic [32*NK-1:0] key);
    logic [31:0]             w [NW];
    logic [31:0]             t;
    logic [7:0]              rcon;
    logic [128*(NR+1)-1:0]   rks;
    rcon = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < NKI) begin
        w[i] = key[32*(NKI-1-i) +: 32];
      end else begin
        t = w[i-1];
        if (i % NKI == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = xtime(rcon);
        end else if (NKI > 6 && i % NKI == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-NKI] ^ t;
      end
    end
    for (int r = 0; r <= NRI; r++) rks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  typedef enum logic [1:0] {StIdle, StSub, StRnd, StOut} st_e;

  st_e                    st_q, st_d;
  logic                   ready_q, valid_q;
  logic                   accept, sub_en, rnd_en, last_rnd;
  logic [127:0]           aes_state_q;
  logic [3:0]             round_ctr_q;
  logic [TAG_W-1:0]       tag_q, out_tag_q;
  logic [127:0]           ct_q;
  logic [127:0]           rk_q [NR+1];
  logic [128*(NR+1)-1:0]  rk_exp;
  logic [127:0]           rk_cur, sr, mc, rnd_out;

  assign rk_exp   = key_expand(i_key);
  assign last_rnd = (round_ctr_q == 4'(NR));

  // State register; ready/valid are registered from the next state so no input reaches an output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      ready_q <= (st_d == StIdle);
      valid_q <= (st_d == StOut);
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (accept) st_d = StSub;
      StSub:   st_d = StRnd;
      StRnd:   st_d = last_rnd ? StOut : StSub;
      StOut:   if (o_ready) st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    sub_en = 1'b0;
    rnd_en = 1'b0;
    case (st_q)
      StIdle:  accept = ready_q & i_valid;
      StSub:   sub_en = 1'b1;
      StRnd:   rnd_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rk_cur = '0;
    for (int r = 0; r <= NRI; r++) begin
      if (round_ctr_q == 4'(r)) rk_cur = rk_q[r];
    end
    sr      = shift_rows(aes_state_q);
    mc      = mix_columns(sr);
    rnd_out = (last_rnd ? sr : mc) ^ rk_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_state_q <= '0;
      round_ctr_q <= '0;
      tag_q       <= '0;
      ct_q        <= '0;
      out_tag_q   <= '0;
      for (int r = 0; r <= NRI; r++) rk_q[r] <= '0;
    end else begin
      if (accept) begin
        aes_state_q <= i_plaintext ^ rk_exp[127:0];
        round_ctr_q <= 4'd1;
        tag_q       <= i_tag;
        for (int r = 0; r <= NRI; r++) rk_q[r] <= rk_exp[128*r +: 128];
      end else if (sub_en) begin
        aes_state_q <= sub_bytes(aes_state_q);
      end else if (rnd_en) begin
        aes_state_q <= rnd_out;
        if (last_rnd) begin
          ct_q      <= rnd_out;
          out_tag_q <= tag_q;
        end else begin
          round_ctr_q <= round_ctr_q + 4'd1;
        end
      end
    end
  end

  assign i_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_ciphertext = ct_q;
  assign o_tag        = out_tag_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors for all key lengths, stall, back-to-back
// and mid-block reset.
module tb_aes_iter_core;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk, rst, o_ready;
  logic [127:0] pt;
  logic [3:0]   tag;
  logic [127:0] key_128;
  logic [191:0] key_192;
  logic [255:0] key_256;
  logic         valid_128, valid_192, valid_256;
  logic         ready_128, ready_192, ready_256;
  logic         ovalid_128, ovalid_192, ovalid_256;
  logic [127:0] ct_128, ct_192, ct_256;
  logic [3:0]   otag_128, otag_192, otag_256;

  int n_tests = 0;
  int n_fail  = 0;

  aes_iter_core #(.NK(4), .TAG_W(4)) u_aes128 (
    .clk(clk), .rst(rst), .i_valid(valid_128), .i_ready(ready_128), .i_plaintext(pt),
    .i_key(key_128), .i_tag(tag), .o_valid(ovalid_128), .o_ready(o_ready),
    .o_ciphertext(ct_128), .o_tag(otag_128)
  );

  aes_iter_core #(.NK(6), .TAG_W(4)) u_aes192 (
    .clk(clk), .rst(rst), .i_valid(valid_192), .i_ready(ready_192), .i_plaintext(pt),
    .i_key(key_192), .i_tag(tag), .o_valid(ovalid_192), .o_ready(o_ready),
    .o_ciphertext(ct_192), .o_tag(otag_192)
  );

  aes_iter_core #(.NK(8), .TAG_W(4)) u_aes256 (
    .clk(clk), .rst(rst), .i_valid(valid_256), .i_ready(ready_256), .i_plaintext(pt),
    .i_key(key_256), .i_tag(tag), .o_valid(ovalid_256), .o_ready(o_ready),
    .o_ciphertext(ct_256), .o_tag(otag_256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Cycles from the accept edge until o_valid of the 128-bit core is seen; 0 on timeout.
  task automatic wait_out128(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ovalid_128) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat128, lat192, lat256, lat, seen, nev;
    logic         prev;
    logic [127:0] c128, c192, c256;
    logic [3:0]   t128, t192, t256;
    int           ev_n   [2];
    logic [127:0] ev_ct  [2];
    logic [3:0]   ev_tag [2];

    rst = 1'b1; o_ready = 1'b1; pt = '0; tag = '0;
    key_128 = '0; key_192 = '0; key_256 = '0;
    valid_128 = 1'b0; valid_192 = 1'b0; valid_256 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out128", 160'({ready_128, ovalid_128, otag_128, ct_128}), 160'(0));
    check_eq("rst_out192", 160'({ready_192, ovalid_192, otag_192, ct_192}), 160'(0));
    check_eq("rst_out256", 160'({ready_256, ovalid_256, otag_256, ct_256}), 160'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 160'({ready_128, ready_192, ready_256}), 160'(3'b111));

    // FIPS-197 appendix C vectors on all three key lengths at once.
    key_128 = K128; key_192 = K192; key_256 = K256; pt = PT_A; tag = 4'h5;
    valid_128 = 1'b1; valid_192 = 1'b1; valid_256 = 1'b1;
    @(posedge clk);
    #1;
    valid_128 = 1'b0; valid_192 = 1'b0; valid_256 = 1'b0;
    lat128 = 0; lat192 = 0; lat256 = 0;
    c128 = '0; c192 = '0; c256 = '0; t128 = '0; t192 = '0; t256 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ovalid_128 && lat128 == 0) begin lat128 = n; c128 = ct_128; t128 = otag_128; end
      if (ovalid_192 && lat192 == 0) begin lat192 = n; c192 = ct_192; t192 = otag_192; end
      if (ovalid_256 && lat256 == 0) begin lat256 = n; c256 = ct_256; t256 = otag_256; end
    end
    check_eq("lat128", 160'(lat128), 160'(20));
    check_eq("ct128", 160'(c128), 160'(CT128));
    check_eq("tag128", 160'(t128), 160'(4'h5));
    check_eq("lat192", 160'(lat192), 160'(24));
    check_eq("ct192", 160'(c192), 160'(CT192));
    check_eq("tag192", 160'(t192), 160'(4'h5));
    check_eq("lat256", 160'(lat256), 160'(28));
    check_eq("ct256", 160'(c256), 160'(CT256));
    check_eq("tag256", 160'(t256), 160'(4'h5));
    check_eq("idle_after", 160'({ovalid_128, ready_128, ovalid_256, ready_256}), 160'(4'b0101));

    // Back-pressure: result must hold while a new block is offered.
    @(negedge clk);
    key_128 = K_B; pt = PT_B; tag = 4'h3; o_ready = 1'b0; valid_128 = 1'b1;
    @(posedge clk);
    #1;
    valid_128 = 1'b0;
    wait_out128(lat);
    check_eq("bp_lat", 160'(lat), 160'(20));
    check_eq("bp_ct", 160'(ct_128), 160'(CT_B));
    key_128 = K128; pt = PT_A; tag = 4'h9; valid_128 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_eq("bp_hold", 160'({ovalid_128, ready_128, otag_128, ct_128}),
               160'({1'b1, 1'b0, 4'h3, CT_B}));
    end
    o_ready = 1'b1; valid_128 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("bp_release", 160'({ovalid_128, ready_128}), 160'(2'b01));
    check_eq("bp_ct_held", 160'({otag_128, ct_128}), 160'({4'h3, CT_B}));
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (ovalid_128) seen++;
    end
    check_eq("bp_no_accept", 160'(seen), 160'(0));

    // Back-to-back blocks with different keys.
    @(negedge clk);
    key_128 = K128; pt = PT_A; tag = 4'h1; valid_128 = 1'b1;
    @(posedge clk);
    #1;
    key_128 = K_B; pt = PT_B; tag = 4'h2;
    nev = 0; prev = 1'b0;
    ev_n[0] = 0; ev_n[1] = 0; ev_ct[0] = '0; ev_ct[1] = '0; ev_tag[0] = '0; ev_tag[1] = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 22) valid_128 = 1'b0;
      if (ovalid_128 && !prev) begin
        if (nev < 2) begin
          ev_n[nev] = n; ev_ct[nev] = ct_128; ev_tag[nev] = otag_128;
        end
        nev++;
      end
      prev = ovalid_128;
    end
    valid_128 = 1'b0;
    check_eq("b2b_count", 160'(nev), 160'(2));
    check_eq("b2b_first_lat", 160'(ev_n[0]), 160'(20));
    check_eq("b2b_spacing", 160'(ev_n[1] - ev_n[0]), 160'(22));
    check_eq("b2b_res0", 160'({ev_tag[0], ev_ct[0]}), 160'({4'h1, CT128}));
    check_eq("b2b_res1", 160'({ev_tag[1], ev_ct[1]}), 160'({4'h2, CT_B}));

    // Asynchronous reset during round 5.
    @(negedge clk);
    key_128 = K128; pt = PT_A; tag = 4'h6; valid_128 = 1'b1;
    @(posedge clk);
    #1;
    valid_128 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_clear", 160'({ready_128, ovalid_128, otag_128, ct_128}), 160'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", 160'(ready_128), 160'(1));
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (ovalid_128) seen++;
    end
    check_eq("mid_rst_no_out", 160'(seen), 160'(0));
    key_128 = K_B; pt = PT_B; tag = 4'h7; valid_128 = 1'b1;
    @(posedge clk);
    #1;
    valid_128 = 1'b0;
    wait_out128(lat);
    check_eq("fresh_lat", 160'(lat), 160'(20));
    check_eq("fresh_res", 160'({otag_128, ct_128}), 160'({4'h7, CT_B}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
